// File: rtl/div_iter_unit.sv
`default_nettype none
// ============================================================================
// Module      : div_iter_unit
// Description : Multi-cycle radix-2 restoring integer divider for the EX
//               stage. Serves MIPS DIV/DIVU requests, holds the pipeline via
//               div_stall and returns {remainder, quotient} for HI/LO.
// Revision    : 1.0 - initial release
// ============================================================================
module div_iter_unit #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               valid,
    input  logic               sign,
    output logic               div_stall,
    output logic               ready,
    output logic [2*WIDTH-1:0] result
);

    localparam int                 c_CNT_W   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST    = c_CNT_W'(WIDTH - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE = c_CNT_W'(1);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_BUSY = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic               w_accept;
    logic               w_last;

    logic [c_CNT_W-1:0] r_count;
    logic [WIDTH-1:0]   r_rem;      // partial remainder
    logic [WIDTH-1:0]   r_quo;      // dividend bits shift out, quotient bits shift in
    logic [WIDTH-1:0]   r_div;      // divisor magnitude
    logic [WIDTH-1:0]   r_a_raw;    // original dividend, returned on divide by zero
    logic               r_dvz;
    logic               r_q_neg;
    logic               r_r_neg;
    logic [2*WIDTH-1:0] r_result;

    // Operand magnitudes; sign bits only matter for signed (DIV) requests
    logic               w_a_neg;
    logic               w_b_neg;
    logic [WIDTH-1:0]   w_a_mag;
    logic [WIDTH-1:0]   w_b_mag;

    assign w_a_neg = sign & a[WIDTH-1];
    assign w_b_neg = sign & b[WIDTH-1];
    assign w_a_mag = w_a_neg ? (-a) : a;
    assign w_b_mag = w_b_neg ? (-b) : b;

    // One restoring step: shift in the next dividend bit, trial-subtract,
    // keep the difference only when it did not borrow
    logic [WIDTH:0]     w_rem_sh;
    logic [WIDTH:0]     w_trial;
    logic               w_borrow;
    logic [WIDTH-1:0]   w_rem_step;
    logic [WIDTH-1:0]   w_quo_step;
    logic [WIDTH-1:0]   w_q_fix;
    logic [WIDTH-1:0]   w_r_fix;
    logic [2*WIDTH-1:0] w_result_nxt;

    assign w_rem_sh     = {r_rem, r_quo[WIDTH-1]};
    assign w_trial      = w_rem_sh - {1'b0, r_div};
    assign w_borrow     = w_trial[WIDTH];
    assign w_rem_step   = w_borrow ? w_rem_sh[WIDTH-1:0] : w_trial[WIDTH-1:0];
    assign w_quo_step   = {r_quo[WIDTH-2:0], ~w_borrow};
    assign w_q_fix      = r_q_neg ? (-w_quo_step) : w_quo_step;
    assign w_r_fix      = r_r_neg ? (-w_rem_step) : w_rem_step;
    // Divide by zero bypasses sign fixup: remainder = dividend, quotient = all ones
    assign w_result_nxt = r_dvz ? {r_a_raw, {WIDTH{1'b1}}} : {w_r_fix, w_q_fix};

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; flush aborts from any state and beats a new request
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_last      = 1'b0;
        if (flush) begin
            w_state_nxt = c_IDLE;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (valid) begin
                        w_state_nxt = c_BUSY;
                        w_accept    = 1'b1;
                    end
                end
                c_BUSY: begin
                    if (r_count == c_LAST) begin
                        w_state_nxt = c_DONE;
                        w_last      = 1'b1;
                    end
                end
                // valid still high here belongs to the finished instruction
                c_DONE:  w_state_nxt = c_IDLE;
                default: w_state_nxt = c_IDLE;
            endcase
        end
    end

    // Datapath: latch operands on accept, iterate while busy, load result on last step
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count  <= '0;
            r_rem    <= '0;
            r_quo    <= '0;
            r_div    <= '0;
            r_a_raw  <= '0;
            r_dvz    <= 1'b0;
            r_q_neg  <= 1'b0;
            r_r_neg  <= 1'b0;
            r_result <= '0;
        end else if (flush) begin
            r_count <= '0;
        end else if (w_accept) begin
            r_count <= '0;
            r_rem   <= '0;
            r_quo   <= w_a_mag;
            r_div   <= w_b_mag;
            r_a_raw <= a;
            r_dvz   <= (b == '0);
            r_q_neg <= w_a_neg ^ w_b_neg;
            r_r_neg <= w_a_neg;
        end else if (r_state == c_BUSY) begin
            r_count <= r_count + c_CNT_ONE;
            r_rem   <= w_rem_step;
            r_quo   <= w_quo_step;
            if (w_last) begin
                r_result <= w_result_nxt;
            end
        end
    end

    assign div_stall = ~rst & ~flush & (((r_state == c_IDLE) & valid) | (r_state == c_BUSY));
    assign ready     = (r_state == c_DONE) & ~flush;
    assign result    = r_result;

endmodule
`default_nettype wire

// File: tb/tb_div_iter_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_div_iter_unit
// Description : Self-checking bench for div_iter_unit. Directed divisions
//               with literal expectations plus an arithmetic reference model
//               checked against result on every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_div_iter_unit;

    logic        clk;
    logic        rst;
    logic        flush;
    logic [31:0] a;
    logic [31:0] b;
    logic        valid;
    logic        sign;
    logic        div_stall;
    logic        ready;
    logic [63:0] result;

    int          n_tests;
    int          n_fail;
    logic [63:0] exp_q[$];
    logic [63:0] exp_res;

    div_iter_unit #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .a         (a),
        .b         (b),
        .valid     (valid),
        .sign      (sign),
        .div_stall (div_stall),
        .ready     (ready),
        .result    (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: plain integer division in 64-bit arithmetic (truncating,
    // remainder takes the dividend's sign); b == 0 returns {a, all ones}
    function automatic logic [63:0] model(input logic [31:0] ma, input logic [31:0] mb, input logic ms);
        longint sa;
        longint sb;
        longint q;
        longint r;
        if (mb == 32'd0) return {ma, 32'hFFFFFFFF};
        if (ms) begin
            sa = longint'($signed(ma));
            sb = longint'($signed(mb));
        end else begin
            sa = longint'({32'd0, ma});
            sb = longint'({32'd0, mb});
        end
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, expv);
        end
    endtask

    // Compare process: result must always equal the last completed model value
    initial begin : compare
        exp_res = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                exp_res = '0;
            end else begin
                if (ready) begin
                    if (exp_q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL unexpected_ready: got ready=1 expected ready=0");
                    end else begin
                        exp_res = exp_q.pop_front();
                    end
                end
                chk("result_vs_model", result, exp_res);
            end
        end
    end

    task automatic start_op(input logic [31:0] ta, input logic [31:0] tb_, input logic ts, input bit push);
        @(posedge clk);
        #1;
        rst   = 1'b0;
        flush = 1'b0;
        a     = ta;
        b     = tb_;
        sign  = ts;
        valid = 1'b1;
        if (push) exp_q.push_back(model(ta, tb_, ts));
    endtask

    // Counts cycles from the request cycle to ready; scrambles operands once busy
    task automatic wait_done(input logic [31:0] ta, input logic [31:0] tb_, input logic ts,
                             input logic [63:0] lit, input string nm);
        int lat;
        int stalls;
        bit got;
        lat    = 0;
        stalls = 0;
        got    = 0;
        while (!got && lat < 100) begin
            @(negedge clk);
            lat++;
            if (div_stall) stalls++;
            if (ready) begin
                got = 1;
                chk({nm, "_result"}, result, lit);
                chk({nm, "_stall_at_ready"}, 64'(div_stall), 64'd0);
            end else if (lat == 1) begin
                @(posedge clk);
                #1;
                a    = ~ta;
                b    = tb_ + 32'd1;
                sign = ~ts;
            end
        end
        chk({nm, "_ready_cycle"}, 64'(lat), 64'd34);
        chk({nm, "_stall_cycles"}, 64'(stalls), 64'd33);
    endtask

    task automatic do_div(input logic [31:0] ta, input logic [31:0] tb_, input logic ts,
                          input logic [63:0] lit, input string nm);
        start_op(ta, tb_, ts, 1'b1);
        wait_done(ta, tb_, ts, lit, nm);
        @(posedge clk);
        #1;
        valid = 1'b0;
        @(negedge clk);
        chk({nm, "_idle_after"}, {62'd0, div_stall, ready}, 64'd0);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        n_tests = 0;
        n_fail  = 0;
        rst   = 1'b1;
        flush = 1'b0;
        valid = 1'b0;
        sign  = 1'b0;
        a     = '0;
        b     = '0;
        #1;
        chk("reset_result", result, 64'd0);
        chk("reset_outs", {62'd0, div_stall, ready}, 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("idle_after_reset", {62'd0, div_stall, ready}, 64'd0);

        // Model pins against hand-computed values
        chk("model_pin_u", model(32'd100, 32'd7, 1'b0), {32'd2, 32'd14});
        chk("model_pin_s", model(32'hFFFFFFF9, 32'd2, 1'b1), {32'hFFFFFFFF, 32'hFFFFFFFD});
        chk("model_pin_ovf", model(32'h80000000, 32'hFFFFFFFF, 1'b1), {32'h0, 32'h80000000});

        do_div(32'd100,       32'd7,        1'b0, {32'd2, 32'd14},                   "u100_7");
        do_div(32'hFFFFFFF9,  32'd2,        1'b1, {32'hFFFFFFFF, 32'hFFFFFFFD},      "s_m7_2");
        do_div(32'hFFFFFFF9,  32'd2,        1'b0, {32'h00000001, 32'h7FFFFFFC},      "u_big_2");
        do_div(32'h80000000,  32'hFFFFFFFF, 1'b1, {32'h00000000, 32'h80000000},      "s_ovf");
        do_div(32'h12345678,  32'd0,        1'b0, {32'h12345678, 32'hFFFFFFFF},      "u_dz");
        do_div(32'hFFFFFF00,  32'd0,        1'b1, {32'hFFFFFF00, 32'hFFFFFFFF},      "s_dz_neg");
        do_div(32'd7,         32'hFFFFFFFE, 1'b1, {32'h00000001, 32'hFFFFFFFD},      "s_7_m2");
        do_div(32'hFFFFFF9C,  32'hFFFFFFF9, 1'b1, {32'hFFFFFFFE, 32'h0000000E},      "s_m100_m7");

        // Flush on the 10th busy cycle, valid kept high so flush must dominate
        start_op(32'd5000, 32'd3, 1'b0, 1'b0);
        repeat (10) @(posedge clk);
        #1;
        flush = 1'b1;
        @(negedge clk);
        chk("flush_outs", {62'd0, div_stall, ready}, 64'd0);
        chk("flush_result_kept", result, {32'hFFFFFFFE, 32'h0000000E});
        do_div(32'd1000, 32'd10, 1'b0, {32'd0, 32'd100}, "after_flush");

        // Asynchronous reset between clock edges in the middle of a division
        start_op(32'h11111111, 32'd3, 1'b0, 1'b0);
        repeat (5) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_outs", {62'd0, div_stall, ready}, 64'd0);
        chk("async_rst_result", result, 64'd0);
        exp_q.delete();
        @(negedge clk);
        do_div(32'hDEADBEEF, 32'd16, 1'b0, {32'h0000000F, 32'h0DEADBEE}, "after_rst");

        // valid held through DONE, next instruction right behind it
        start_op(32'd50, 32'd3, 1'b0, 1'b1);
        wait_done(32'd50, 32'd3, 1'b0, {32'd2, 32'd16}, "b2b_first");
        @(posedge clk);
        #1;
        a    = 32'd81;
        b    = 32'd9;
        sign = 1'b1;
        exp_q.push_back(model(32'd81, 32'd9, 1'b1));
        wait_done(32'd81, 32'd9, 1'b1, {32'd0, 32'd9}, "b2b_second");
        @(posedge clk);
        #1;
        valid = 1'b0;
        @(negedge clk);
        chk("b2b_idle_after", {62'd0, div_stall, ready}, 64'd0);
        chk("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
